// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg : shared state encoding and line constants for fifo_uart_tx. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt : per-bit cycle counter, bit_tick on the last cycle of a bit. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign bit_tick = (baud_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx : pops words from a FIFO and serialises them as UART frames.
// Optional even parity bit when UART_TX_PARITY_EN is defined.         Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DWIDTH) + 1;

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  uart_tx_state_t    state, state_next;
  logic [DWIDTH-1:0] shift_reg;
  logic [DWIDTH-1:0] data_sh;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic              tx_next;
  logic              bit_tick;
  logic              baud_clear;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty && !rst) begin
          fifo_pop   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:  state_next = START;
      START: if (bit_tick) state_next = DATA;
      DATA: begin
        if (bit_tick && bit_cnt == BW'(DWIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (bit_tick) state_next = STOP;
      STOP: begin
        if (bit_tick && bit_cnt == BW'(STOP_BITS - 1)) begin
          state_next = IDLE;
          frame_done = !rst;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters restart on every state change; bit_cnt also counts stop bits.
  assign baud_clear   = (state_next != state) || (state == IDLE);
  assign bit_cnt_next = (state_next != state) ? '0 :
                        bit_tick              ? bit_cnt + 1'b1 : bit_cnt;
  assign data_sh      = shift_reg >> bit_cnt_next;

  // tx is registered, so its next value follows the state being entered.
  always_comb begin
    tx_next = UART_IDLE_LEVEL;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_sh[0];
      PARITY:  tx_next = ^shift_reg;
      default: tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= UART_IDLE_LEVEL;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      tx      <= tx_next;
      bit_cnt <= bit_cnt_next;
      if (state == LOAD) begin
        shift_reg <= fifo_dout;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx : directed bench, 4-deep FIFO model feeding fifo_uart_tx. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + 8 + P + 1;
  localparam int L     = CPB * NBITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_pop, tx, busy, frame_done;

  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fmem [4];
  int         fwp = 0, frp = 0, fcnt = 0;
  int         pops = 0, underflow = 0, bad_pop = 0;

  int         n_tests = 0, n_fail = 0;
  logic [NBITS-1:0] last_lv;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DWIDTH       (8),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  assign fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    int c;
    c = fcnt;
    if (fifo_pop) begin
      pops <= pops + 1;
      if (busy) bad_pop <= bad_pop + 1;
      if (c == 0) begin
        underflow <= underflow + 1;
      end else begin
        fifo_dout <= fmem[frp];
        frp <= (frp + 1) % 4;
        c = c - 1;
      end
    end
    if (push) begin
      fmem[fwp] <= push_data;
      fwp <= (fwp + 1) % 4;
      c = c + 1;
    end
    fcnt <= c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the number of negedges stepped until tx is seen low.
  task automatic wait_start(output int n);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic rx_frame(output logic [7:0] d, output logic [NBITS-1:0] lv,
                          output int bad, output int fd_at, output int fd_n);
    bad = 0; fd_at = -1; fd_n = 0; lv = '0;
    for (int c = 0; c < L; c++) begin
      if (c != 0) @(negedge clk);
      if (c % CPB == 0) lv[c / CPB] = tx;
      else if (tx !== lv[c / CPB]) bad++;
      if (frame_done) begin
        fd_n++;
        fd_at = c;
      end
    end
    d = lv[8:1];
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp_d);
    logic [7:0] d;
    logic [NBITS-1:0] lv;
    int bad, fd_at, fd_n;
    rx_frame(d, lv, bad, fd_at, fd_n);
    last_lv = lv;
    check({tag, "_start"}, lv[0], 1'b0);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_stop"}, lv[NBITS-1], 1'b1);
    check({tag, "_bit_width"}, bad, 0);
    check({tag, "_done_pos"}, fd_at, L - 1);
    check({tag, "_done_cnt"}, fd_n, 1);
  endtask

  task automatic push_words(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int n);
    logic [7:0] ws [3];
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    push = 1'b1;
    for (int i = 0; i < n; i++) begin
      push_data = ws[i];
      @(negedge clk);
    end
    push = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

  initial begin
    int n, viol, p0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_pop", fifo_pop, 1'b0);
    rst = 1'b0;

    // Empty FIFO, enabled: line stays idle, nothing popped
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) viol++;
    end
    check("idle_quiet", viol, 0);
    check("idle_no_pop", pops, 0);

    // Single word 0xA5: pop one cycle after push, tx low two cycles after pop
    push_words(8'hA5, 8'h00, 8'h00, 1);
    check("pop_latency", fifo_pop, 1'b1);
    wait_start(n);
    check("start_latency", n, 2);
    expect_frame("a5", 8'hA5);
    check("a5_pops", pops, 1);

    // Three words back to back
    repeat (3) @(negedge clk);
    push_words(8'h01, 8'h02, 8'h03, 3);
    wait_start(n);
    expect_frame("w1", 8'h01);
    wait_start(n);
    check("gap_12", n, 3);
    expect_frame("w2", 8'h02);
    wait_start(n);
    check("gap_23", n, 3);
    expect_frame("w3", 8'h03);
    repeat (5) @(negedge clk);
    check("b2b_pops", pops, 4);
    check("b2b_empty", fcnt, 0);
    check("b2b_underflow", underflow, 0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones -> 1, 0x03 has two ones -> 0
    push_words(8'h07, 8'h00, 8'h00, 1);
    wait_start(n);
    expect_frame("p07", 8'h07);
    check("p07_parity", last_lv[9], 1'b1);
    repeat (3) @(negedge clk);
    push_words(8'h03, 8'h00, 8'h00, 1);
    wait_start(n);
    expect_frame("p03", 8'h03);
    check("p03_parity", last_lv[9], 1'b0);
    repeat (3) @(negedge clk);
`endif

    // Reset during data bit 3 of 0x5A; 0xC3 must follow intact
    p0 = pops;
    push_words(8'h5A, 8'hC3, 8'h00, 2);
    wait_start(n);
    repeat (17) @(negedge clk);
    check("mid_bit3", tx, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    wait_start(n);
    check("midrst_restart", n, 2);
    expect_frame("c3", 8'hC3);
    check("midrst_pops", pops - p0, 2);

    // en low: nothing popped; dropping en mid-frame lets the frame finish
    repeat (3) @(negedge clk);
    en = 1'b0;
    p0 = pops;
    push_words(8'h11, 8'h22, 8'h00, 2);
    repeat (20) @(negedge clk);
    check("en0_pops", pops - p0, 0);
    check("en0_busy", busy, 1'b0);
    check("en0_fifo", fcnt, 2);
    en = 1'b1;
    fork
      begin
        int m;
        wait_start(m);
        expect_frame("e11", 8'h11);
      end
      begin
        repeat (8) @(negedge clk);
        en = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("en_drop_pops", pops - p0, 1);
    check("en_drop_fifo", fcnt, 1);
    check("en_drop_tx", tx, 1'b1);
    en = 1'b1;
    wait_start(n);
    expect_frame("e22", 8'h22);
    repeat (5) @(negedge clk);
    check("final_empty", fcnt, 0);
    check("final_underflow", underflow, 0);
    check("final_pop_while_busy", bad_pop, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
